// File: rtl/adc_sample_conditioner_if.sv
// adc_sample_conditioner_if
// Bundles the XADC conversion result bus and the conditioned rail outputs.
//   do_in/channel_in/drdy_in : conversion result, channel address, valid strobe
//   volt_out/volt_other      : filtered 5V / sharing-rail averages
//   drdy_out/drdy_other      : one-cycle update strobes for the averages
//   spike_flag               : one-cycle pulse when a sample was rejected
interface adc_sample_conditioner_if;
  logic [15:0] do_in;
  logic [4:0]  channel_in;
  logic        drdy_in;
  logic [11:0] volt_out;
  logic [11:0] volt_other;
  logic        drdy_out;
  logic        drdy_other;
  logic        spike_flag;

  modport master (
    output do_in, channel_in, drdy_in,
    input  volt_out, volt_other, drdy_out, drdy_other, spike_flag
  );

  modport slave (
    input  do_in, channel_in, drdy_in,
    output volt_out, volt_other, drdy_out, drdy_other, spike_flag
  );
endinterface

// File: rtl/adc_sample_conditioner.sv
// adc_sample_conditioner
// Two-rail XADC sample conditioner: 4-tap moving average per channel with
// spike rejection (rejected samples replaced by the current average, bounded
// number of consecutive rejections so a real step still passes through).
//   clk      : system clock, rising edge
//   reset_in : synchronous active-high reset
//   bus      : adc_sample_conditioner_if.slave (sample in, averages/strobes out)
// Latency: sample cycle N -> spike decision at edge N+1 -> commit/strobe at N+2.

// Per-channel averaging state. Exposes its next-state values so a sample in
// the check stage sees the effect of the sample committing on the same edge.
module adc_sc_chan #(
  parameter int W  = 12,
  parameter int SW = 14
) (
  input  logic         clk,
  input  logic         reset_in,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_val_i,
  input  logic [1:0]   wr_rej_i,
  output logic         primed_o,
  output logic [W-1:0] avg_o,
  output logic [1:0]   rej_o
);
  typedef enum logic [1:0] {PRIME, TRACK, SUSPECT} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    buf_q [4];
  logic [1:0]      ptr_q;
  logic [SW-1:0]   sum_q, sum_d;
  logic [2:0]      fill_q;
  logic [1:0]      rej_q, rej_d;
  logic [W-1:0]    oldest;

  always_comb begin
    // Unfilled slots contribute nothing to the running sum.
    oldest  = (fill_q == 3'd4) ? buf_q[ptr_q] : '0;
    sum_d   = sum_q;
    rej_d   = rej_q;
    state_d = state_q;
    if (wr_en_i) begin
      sum_d = sum_q + SW'(wr_val_i) - SW'(oldest);
      rej_d = wr_rej_i;
      case (state_q)
        PRIME:   if (fill_q == 3'd3) state_d = TRACK;
        TRACK:   if (wr_rej_i != 2'd0) state_d = SUSPECT;
        default: if (wr_rej_i == 2'd0) state_d = TRACK;
      endcase
    end
  end

  assign primed_o = (state_d != PRIME);
  assign avg_o    = sum_d[SW-1:2];
  assign rej_o    = rej_d;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
      fill_q  <= '0;
      rej_q   <= '0;
      state_q <= PRIME;
    end else begin
      if (wr_en_i) begin
        buf_q[ptr_q] <= wr_val_i;
        ptr_q        <= ptr_q + 2'd1;
        if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
      end
      sum_q   <= sum_d;
      rej_q   <= rej_d;
      state_q <= state_d;
    end
  end
endmodule

module adc_sample_conditioner #(
  parameter logic [4:0]  CH_5V       = 5'h10,
  parameter logic [4:0]  CH_OTHER    = 5'h11,
  parameter logic [11:0] SPIKE_LIMIT = 12'd300,
  parameter logic [1:0]  MAX_REJECT  = 2'd2
) (
  input  logic                     clk,
  input  logic                     reset_in,
  adc_sample_conditioner_if.slave  bus
);
  localparam int NCH = 2;
  localparam int W   = 12;

  logic [NCH-1:0]        hit;
  logic                  cur;
  logic [W-1:0]          smp;
  logic                  unused_nib;
  logic [NCH-1:0]        wr_en, primed_d;
  logic [NCH-1:0][W-1:0] avg_d;
  logic [NCH-1:0][1:0]   rej_d;

  // check stage
  logic                  s1_vld_q, s1_ch_q, s1_spk_q;
  logic [W-1:0]          s1_val_q;
  logic [1:0]            s1_rej_q;
  logic [W-1:0]          avg_c, diff, val_d;
  logic [1:0]            rej_n;
  logic                  spk_d;

  // outputs
  logic [NCH-1:0]        stb_q;
  logic [NCH-1:0][W-1:0] volt_q;
  logic                  spike_q;

  assign smp        = bus.do_in[15:4];
  assign unused_nib = ^bus.do_in[3:0];
  assign hit[0]     = bus.drdy_in && (bus.channel_in == CH_5V);
  assign hit[1]     = bus.drdy_in && (bus.channel_in == CH_OTHER);
  assign cur        = !hit[0];

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      assign wr_en[c] = s1_vld_q && (s1_ch_q == 1'(c));
      adc_sc_chan #(.W(W), .SW(14)) u_chan (
        .clk      (clk),
        .reset_in (reset_in),
        .wr_en_i  (wr_en[c]),
        .wr_val_i (s1_val_q),
        .wr_rej_i (s1_rej_q),
        .primed_o (primed_d[c]),
        .avg_o    (avg_d[c]),
        .rej_o    (rej_d[c])
      );
    end
  endgenerate

  // Spike decision against forwarded (post-commit) channel state. Once the
  // reject budget is spent the out-of-limit sample is taken as-is and the
  // counter clears, same as an in-limit sample.
  always_comb begin
    avg_c = avg_d[cur];
    diff  = (smp >= avg_c) ? (smp - avg_c) : (avg_c - smp);
    val_d = smp;
    rej_n = '0;
    spk_d = 1'b0;
    if (primed_d[cur] && (diff > SPIKE_LIMIT) && (rej_d[cur] != MAX_REJECT)) begin
      val_d = avg_c;
      rej_n = rej_d[cur] + 2'd1;
      spk_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      s1_vld_q <= 1'b0;
      s1_ch_q  <= 1'b0;
      s1_val_q <= '0;
      s1_rej_q <= '0;
      s1_spk_q <= 1'b0;
      stb_q    <= '0;
      volt_q   <= '0;
      spike_q  <= 1'b0;
    end else begin
      s1_vld_q <= |hit;
      s1_ch_q  <= cur;
      s1_val_q <= val_d;
      s1_rej_q <= rej_n;
      s1_spk_q <= spk_d;
      spike_q  <= s1_vld_q && s1_spk_q;
      for (int i = 0; i < NCH; i++) begin
        // Strobe only once the channel holds four samples.
        stb_q[i] <= wr_en[i] && primed_d[i];
        if (wr_en[i] && primed_d[i]) volt_q[i] <= avg_d[i];
      end
    end
  end

  assign bus.volt_out   = volt_q[0];
  assign bus.volt_other = volt_q[1];
  assign bus.drdy_out   = stb_q[0];
  assign bus.drdy_other = stb_q[1];
  assign bus.spike_flag = spike_q;
endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Bench for adc_sample_conditioner: randomized and directed samples, checked
// every cycle against a queue-based moving-average model plus literal values.
module tb_adc_sample_conditioner;
  localparam logic [4:0] CH5  = 5'h10;
  localparam logic [4:0] CHO  = 5'h11;
  localparam int         LIM  = 300;
  localparam int         MAXR = 2;
  localparam int         N    = 8192;

  logic clk = 1'b0;
  logic reset_in = 1'b0;
  always #5 clk = ~clk;

  adc_sample_conditioner_if bus();

  adc_sample_conditioner #(
    .CH_5V(CH5), .CH_OTHER(CHO), .SPIKE_LIMIT(12'd300), .MAX_REJECT(2'd2)
  ) u_dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected events indexed by the cycle whose outputs they describe
  bit ev_v[N];
  int ev_ch[N];
  bit ev_stb[N];
  int ev_val[N];
  bit ev_spk[N];
  bit rst_at[N];

  // model: last four written values per channel, reject counter per channel
  int hist[2][$];
  int rej[2];

  int checks = 0, errors = 0;
  int held[2];
  bit chk_en = 0;
  int n_do = 0, n_dot = 0, n_spk = 0;

  typedef struct {string name; int act; int exp;} lit_t;
  lit_t litq[$];

  task automatic cmp(input string nm, input int act, input int exp, input int k);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int k;
    lit_t l;
    bit e0, e1, es;
    if (chk_en) begin
      k  = cyc;
      e0 = 0; e1 = 0; es = 0;
      if (rst_at[k]) begin
        held[0] = 0; held[1] = 0;
      end else if (ev_v[k]) begin
        es = ev_spk[k];
        if (ev_stb[k]) begin
          held[ev_ch[k]] = ev_val[k];
          if (ev_ch[k] == 0) e0 = 1; else e1 = 1;
        end
      end
      if (bus.drdy_out === 1'b1)   n_do++;
      if (bus.drdy_other === 1'b1) n_dot++;
      if (bus.spike_flag === 1'b1) n_spk++;
      cmp("drdy_out",   int'(bus.drdy_out),   int'(e0), k);
      cmp("drdy_other", int'(bus.drdy_other), int'(e1), k);
      cmp("spike_flag", int'(bus.spike_flag), int'(es), k);
      cmp("volt_out",   int'(bus.volt_out),   held[0], k);
      cmp("volt_other", int'(bus.volt_other), held[1], k);
      while (litq.size() > 0) begin
        l = litq.pop_front();
        cmp(l.name, l.act, l.exp, k);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    lit_t l;
    l.name = nm; l.act = act; l.exp = exp;
    litq.push_back(l);
  endtask

  function automatic int qsum(input int i);
    int s = 0;
    for (int j = 0; j < hist[i].size(); j++) s += hist[i][j];
    return s;
  endfunction

  // Sequential spec-level model: the sample's effect appears at cycle k.
  task automatic mdl(input int i, input int s, input int k);
    int avg, w, d;
    bit spk;
    avg = qsum(i) / 4;
    w   = s;
    spk = 0;
    if (hist[i].size() == 4) begin
      d = (s > avg) ? s - avg : avg - s;
      if (d > LIM) begin
        if (rej[i] == MAXR) rej[i] = 0;
        else begin w = avg; rej[i]++; spk = 1; end
      end else rej[i] = 0;
    end
    hist[i].push_back(w);
    if (hist[i].size() > 4) void'(hist[i].pop_front());
    ev_v[k]   = 1;
    ev_ch[k]  = i;
    ev_stb[k] = (hist[i].size() == 4);
    ev_val[k] = qsum(i) / 4;
    ev_spk[k] = spk;
  endtask

  task automatic drive(input bit v, input logic [4:0] ch, input int s);
    logic [11:0] s12;
    @(posedge clk); #1;
    s12            = 12'(s);
    bus.drdy_in    = v;
    bus.channel_in = ch;
    bus.do_in      = {s12, 4'($urandom_range(15))};
    if (v && ch == CH5) mdl(0, s, cyc + 2);
    else if (v && ch == CHO) mdl(1, s, cyc + 2);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 5'h00, 0);
  endtask

  task automatic do_reset(input int n);
    int c;
    @(posedge clk); #1;
    reset_in    = 1'b1;
    bus.drdy_in = 1'b0;
    c = cyc;
    for (int j = 1; j <= n; j++) rst_at[c + j] = 1;
    for (int j = 1; j <= n + 1; j++) ev_v[c + j] = 0;
    for (int i = 0; i < 2; i++) begin hist[i].delete(); rej[i] = 0; end
    @(posedge clk); #1;
    chk_en = 1;
    repeat (n - 1) @(posedge clk);
    #1 reset_in = 1'b0;
  endtask

  initial begin
    int d0, d1, sp;
    int base[2];
    bus.drdy_in = 0; bus.channel_in = 0; bus.do_in = 0;
    do_reset(3);
    lit("rst_volt_out", int'(bus.volt_out), 0);
    lit("rst_volt_other", int'(bus.volt_other), 0);

    // four 3150 samples: exactly one strobe, average 3150
    d0 = n_do;
    repeat (4) drive(1, CH5, 3150);
    idle(3);
    lit("prime_strobes", n_do - d0, 1);
    lit("prime_volt", int'(bus.volt_out), 3150);
    lit("prime_model", held[0], 3150);

    // 2500 rejected, then two back-to-back: second rejected, third forced
    sp = n_spk;
    drive(1, CH5, 2500);
    idle(3);
    lit("spike1_cnt", n_spk - sp, 1);
    lit("spike1_volt", int'(bus.volt_out), 3150);
    drive(1, CH5, 2500);
    drive(1, CH5, 2500);
    idle(3);
    lit("spike3_cnt", n_spk - sp, 2);
    lit("forced_volt", int'(bus.volt_out), 2987);
    lit("forced_model", held[0], 2987);

    // in-limit step of 250
    do_reset(2);
    repeat (4) drive(1, CH5, 3150);
    sp = n_spk;
    drive(1, CH5, 3400);
    idle(3);
    lit("inlim_spike", n_spk - sp, 0);
    lit("inlim_volt", int'(bus.volt_out), 3212);

    // alternating channels every cycle
    do_reset(2);
    d0 = n_do; d1 = n_dot;
    for (int i = 0; i < 12; i++)
      if (i % 2 == 0) drive(1, CH5, 3150); else drive(1, CHO, 3100);
    idle(3);
    lit("alt_cnt_out", n_do - d0, 3);
    lit("alt_cnt_other", n_dot - d1, 3);
    lit("alt_volt_out", int'(bus.volt_out), 3150);
    lit("alt_volt_other", int'(bus.volt_other), 3100);

    // foreign channel ignored; reset one cycle after a sample kills it
    d0 = n_do;
    drive(1, 5'h03, 100);
    idle(3);
    lit("foreign_volt", int'(bus.volt_out), 3150);
    drive(1, CH5, 3150);
    do_reset(2);
    idle(3);
    lit("rstmid_cnt", n_do - d0, 0);
    lit("rstmid_volt", int'(bus.volt_out), 0);

    // randomized traffic
    base[0] = 2000; base[1] = 1500;
    for (int it = 0; it < 3000; it++) begin
      int r, i, s;
      logic [4:0] ch;
      r = $urandom_range(99);
      if (r < 1) do_reset(1 + $urandom_range(2));
      else if (r < 25) idle(1);
      else begin
        r = $urandom_range(9);
        if (r < 5) begin i = 0; ch = CH5; end
        else if (r < 9) begin i = 1; ch = CHO; end
        else begin
          i = 0;
          ch = 5'($urandom_range(31));
          if (ch == CH5 || ch == CHO) ch = 5'h00;
        end
        if ($urandom_range(49) == 0) base[i] = $urandom_range(3800, 300);
        if ($urandom_range(9) == 0) s = $urandom_range(4095);
        else s = base[i] + int'($urandom_range(200)) - 100;
        if (s < 0) s = 0;
        if (s > 4095) s = 4095;
        drive(1, ch, s);
      end
    end
    idle(4);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
